dmi_arbiter: RTL and testbench
==============================

Name: dmi_arbiter

Overview:
- Shares one debug module interface (DMI) target between two requesters, for example the simulation DTM and a second host or JTAG DTM.
- Allows one outstanding transaction at a time. Arbitration is round-robin.
- Registers each granted request, forwards it to the target, and routes the response back to the requester that owns it.
- A response timeout converts a hung target into an error response, so no requester deadlocks.

Parameters:
- ADDR_W, 7, DMI address width.
- DATA_W, 32, DMI data width.
- TIMEOUT, 1024, cycles to wait in WAIT before returning an error; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rN_req_valid (N=0,1)  in  1  requester N has a request.
- rN_req_ready  out  1  request accepted this cycle.
- rN_req_bits_addr  in  ADDR_W  DMI address.
- rN_req_bits_op  in  2  0=nop, 1=read, 2=write.
- rN_req_bits_data  in  DATA_W  write data.
- rN_resp_valid  out  1  response to requester N is valid.
- rN_resp_ready  in  1  requester N accepts the response.
- rN_resp_bits_resp  out  2  0=ok, 2=failed, 3=busy.
- rN_resp_bits_data  out  DATA_W  read data.
- m_req_valid, m_req_bits_addr, m_req_bits_op, m_req_bits_data  out  1/ADDR_W/2/DATA_W  request to the DMI target.
- m_req_ready  in  1  target accepts the request.
- m_resp_valid, m_resp_bits_resp, m_resp_bits_data  in  1/2/DATA_W  response from the target.
- m_resp_ready  out  1  arbiter accepts the response.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky flag; set on any timeout, cleared only by reset.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (asynchronous):
  - state=IDLE, last_grant=1 (so r0 wins first), owner=0, all latched fields 0, timer=0, timeout_err=0.
  - All valid and ready outputs are 0, except m_resp_ready=1 (the value it takes in IDLE).
- IDLE:
  - grant is combinational. If only one rN_req_valid is set, grant=N. If both are set, grant=!last_grant.
  - rN_req_ready = (state==IDLE) && rN_req_valid && grant==N. At most one ready is high per cycle.
  - On handshake: latch addr/op/data, set owner=N, go to ISSUE.
- ISSUE:
  - m_req_valid=1, carrying only the latched fields, which are stable while valid.
  - On m_req_ready: clear timer, go to WAIT.
  - No timeout applies in ISSUE.
- WAIT:
  - m_resp_ready=1.
  - On m_resp_valid: latch resp/data, go to RESP.
  - Otherwise timer increments. If TIMEOUT!=0 and timer==TIMEOUT-1 with no response: latch resp=2, data=0, set timeout_err, go to RESP.
  - A response arriving in the same cycle as expiry wins; no timeout is flagged.
- RESP:
  - r[owner]_resp_valid=1 with the latched resp/data. The non-owner resp_valid stays 0.
  - On r[owner]_resp_ready: last_grant=owner, go to IDLE.
- Stray responses:
  - m_resp_ready=1 in IDLE, ISSUE and WAIT; 0 in RESP.
  - A response accepted outside WAIT (for example a late reply after a timeout) is dropped silently.
  - A requester never sees a response it does not own.
- op=0 (nop) follows the full path like any other op.
- Minimum transaction length is 4 cycles (accept, issue, response, deliver) when all handshakes are immediate. Back-to-back transactions are possible with no idle cycle, because a grant in IDLE can occur on the cycle after RESP completes.
- Fairness: under continuous requests from both requesters, grants strictly alternate.
- Timer width is clog2(TIMEOUT+1) and the counter saturates.
- Reset mid-transaction: the transaction is abandoned immediately with no response delivered. A late target response after reset is drained in IDLE.

Test Plan:
- Only r0 reads addr 0x11. The target accepts and replies ok with data 0xDEADBEEF after 3 cycles.
  - Response: r0_resp shows resp=0, data=0xDEADBEEF; r1_resp_valid stays 0; busy drops 1 cycle after r0_resp handshake.
- r0 and r1 hold valid continuously, each with 3 writes.
  - Response: grant order r0,r1,r0,r1,r0,r1; each m_req carries that requester's addr/data unchanged.
- TIMEOUT=8; the target accepts the request and never responds.
  - Response: 8 cycles after entering WAIT, the owner gets resp=2, data=0 and timeout_err=1. A reply injected later is dropped, and the next transaction completes normally.
- Owner holds resp_ready=0 for 5 cycles.
  - Response: resp_valid and data stay stable; m_resp_ready=0 throughout; r1's pending request is not granted until the handshake completes.
- Target response arrives exactly on the timeout cycle.
  - Response: resp=target value; timeout_err remains 0.
- Assert reset for 1 cycle during WAIT.
  - Response: all outputs go to reset values immediately; no resp_valid is asserted; the next request is granted to r0 first.

Source files
------------

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI target between two requesters, one transaction in flight.
// Min 4 cycles per transaction; WAIT times out to a failed response; requests stall until IDLE.
module dmi_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [ADDR_W-1:0] r0_req_bits_addr,
  input  logic [1:0]        r0_req_bits_op,
  input  logic [DATA_W-1:0] r0_req_bits_data,
  output logic              r0_resp_valid,
  input  logic              r0_resp_ready,
  output logic [1:0]        r0_resp_bits_resp,
  output logic [DATA_W-1:0] r0_resp_bits_data,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [ADDR_W-1:0] r1_req_bits_addr,
  input  logic [1:0]        r1_req_bits_op,
  input  logic [DATA_W-1:0] r1_req_bits_data,
  output logic              r1_resp_valid,
  input  logic              r1_resp_ready,
  output logic [1:0]        r1_resp_bits_resp,
  output logic [DATA_W-1:0] r1_resp_bits_data,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_bits_addr,
  output logic [1:0]        m_req_bits_op,
  output logic [DATA_W-1:0] m_req_bits_data,
  input  logic              m_resp_valid,
  output logic              m_resp_ready,
  input  logic [1:0]        m_resp_bits_resp,
  input  logic [DATA_W-1:0] m_resp_bits_data,
  output logic              busy,
  output logic              timeout_err
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state, w_next;
  logic              r_last_grant, r_owner, r_timeout_err;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_resp;
  logic [DATA_W-1:0] r_rdata;
  logic [TW-1:0]     r_timer;
  logic              w_grant, w_expire, w_resp_hs;

  // Contention goes to whoever did not win last; a lone requester always wins.
  assign w_grant   = (r0_req_valid && r1_req_valid) ? ~r_last_grant : r1_req_valid;
  assign w_expire  = (TIMEOUT != 0) && (r_timer == T_LAST);
  assign w_resp_hs = r_owner ? r1_resp_ready : r0_resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    r0_req_ready  = 1'b0;
    r1_req_ready  = 1'b0;
    m_req_valid   = 1'b0;
    m_resp_ready  = 1'b1;
    r0_resp_valid = 1'b0;
    r1_resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        r0_req_ready = r0_req_valid && !w_grant;
        r1_req_ready = r1_req_valid && w_grant;
        if (r0_req_valid || r1_req_valid) w_next = ISSUE;
      end
      ISSUE: begin
        m_req_valid = 1'b1;
        if (m_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (m_resp_valid || w_expire) w_next = RESP;
      end
      RESP: begin
        m_resp_ready  = 1'b0;
        r0_resp_valid = !r_owner;
        r1_resp_valid = r_owner;
        if (w_resp_hs) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_addr        <= '0;
      r_op          <= '0;
      r_wdata       <= '0;
      r_resp        <= '0;
      r_rdata       <= '0;
      r_timer       <= '0;
    end else begin
      case (r_state)
        IDLE: if (r0_req_ready || r1_req_ready) begin
          r_owner <= r1_req_ready;
          r_addr  <= r1_req_ready ? r1_req_bits_addr : r0_req_bits_addr;
          r_op    <= r1_req_ready ? r1_req_bits_op   : r0_req_bits_op;
          r_wdata <= r1_req_ready ? r1_req_bits_data : r0_req_bits_data;
        end
        ISSUE: if (m_req_ready) r_timer <= '0;
        WAIT: begin
          // A response on the expiry cycle takes priority over the timeout.
          if (m_resp_valid) begin
            r_resp  <= m_resp_bits_resp;
            r_rdata <= m_resp_bits_data;
          end else begin
            if (r_timer != T_MAX) r_timer <= r_timer + TW'(1);
            if (w_expire) begin
              r_resp        <= 2'd2;
              r_rdata       <= '0;
              r_timeout_err <= 1'b1;
            end
          end
        end
        RESP: if (w_resp_hs) r_last_grant <= r_owner;
        default: ;
      endcase
    end
  end

  assign m_req_bits_addr   = r_addr;
  assign m_req_bits_op     = r_op;
  assign m_req_bits_data   = r_wdata;
  assign r0_resp_bits_resp = r_resp;
  assign r0_resp_bits_data = r_rdata;
  assign r1_resp_bits_resp = r_resp;
  assign r1_resp_bits_data = r_rdata;
  assign busy              = (r_state != IDLE);
  assign timeout_err       = r_timeout_err;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Scoreboard bench for dmi_arbiter: stimulus pushes expected target requests and responses,
// a negedge monitor pops and compares on every handshake.
module tb_dmi_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  typedef struct packed {logic [AW-1:0] a; logic [1:0] op; logic [DW-1:0] d;} mreq_t;
  typedef struct packed {logic [1:0] r; logic [DW-1:0] d;} rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic          req_valid [2];
  logic          req_ready [2];
  logic [AW-1:0] req_addr  [2];
  logic [1:0]    req_op    [2];
  logic [DW-1:0] req_data  [2];
  logic          resp_valid[2];
  logic          resp_rdy  [2];
  logic [1:0]    resp_code [2];
  logic [DW-1:0] resp_data [2];
  logic m_req_valid, m_req_ready, m_resp_valid, m_resp_ready, busy, timeout_err;
  logic [AW-1:0] m_req_addr;
  logic [1:0]    m_req_op, m_resp_code;
  logic [DW-1:0] m_req_data, m_resp_data;

  logic [1:0]    tgt_resp;
  logic [DW-1:0] tgt_data;
  int            tgt_delay;

  mreq_t mq[$];
  rsp_t  rq0[$], rq1[$];
  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk(clk), .reset(rst),
    .r0_req_valid(req_valid[0]), .r0_req_ready(req_ready[0]),
    .r0_req_bits_addr(req_addr[0]), .r0_req_bits_op(req_op[0]), .r0_req_bits_data(req_data[0]),
    .r0_resp_valid(resp_valid[0]), .r0_resp_ready(resp_rdy[0]),
    .r0_resp_bits_resp(resp_code[0]), .r0_resp_bits_data(resp_data[0]),
    .r1_req_valid(req_valid[1]), .r1_req_ready(req_ready[1]),
    .r1_req_bits_addr(req_addr[1]), .r1_req_bits_op(req_op[1]), .r1_req_bits_data(req_data[1]),
    .r1_resp_valid(resp_valid[1]), .r1_resp_ready(resp_rdy[1]),
    .r1_resp_bits_resp(resp_code[1]), .r1_resp_bits_data(resp_data[1]),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_bits_addr(m_req_addr), .m_req_bits_op(m_req_op), .m_req_bits_data(m_req_data),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_bits_resp(m_resp_code), .m_resp_bits_data(m_resp_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Target: always accepts; replies tgt_delay cycles into WAIT.
  initial begin
    m_req_ready = 1'b1; m_resp_valid = 1'b0; m_resp_code = '0; m_resp_data = '0;
    forever begin
      @(negedge clk);
      if (m_req_valid && m_req_ready && !rst) begin
        @(posedge clk); #1;
        repeat (tgt_delay) begin @(posedge clk); #1; end
        m_resp_valid = 1'b1; m_resp_code = tgt_resp; m_resp_data = tgt_data;
        @(posedge clk); #1;
        m_resp_valid = 1'b0;
      end
    end
  end

  initial begin
    mreq_t em;
    rsp_t  er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_req_valid && m_req_ready) begin
          if (mq.size() == 0) chk("mreq_unexpected", 64'(m_req_addr), 64'h0);
          else begin
            em = mq.pop_front();
            chk("mreq", 64'({m_req_addr, m_req_op, m_req_data}), 64'(em));
          end
        end
        if (resp_valid[0]) begin
          if (rq0.size() == 0) chk("r0_resp_stray", 64'(resp_valid[0]), 64'h0);
          else if (resp_rdy[0]) begin
            er = rq0.pop_front();
            chk("r0_resp", 64'({resp_code[0], resp_data[0]}), 64'(er));
          end
        end
        if (resp_valid[1]) begin
          if (rq1.size() == 0) chk("r1_resp_stray", 64'(resp_valid[1]), 64'h0);
          else if (resp_rdy[1]) begin
            er = rq1.pop_front();
            chk("r1_resp", 64'({resp_code[1], resp_data[1]}), 64'(er));
          end
        end
      end
    end
  end

  task automatic send(input int n, input logic [AW-1:0] a, input logic [1:0] op, input logic [DW-1:0] d);
    int k = 0;
    req_valid[n] = 1'b1; req_addr[n] = a; req_op[n] = op; req_data[n] = d;
    @(negedge clk);
    while (!req_ready[n] && k < 300) begin @(negedge clk); k++; end
    if (!req_ready[n]) chk($sformatf("req%0d_grant_wait", n), 64'h0, 64'h1);
    @(posedge clk); #1;
    req_valid[n] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((mq.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && k < 400) begin
      @(posedge clk); #2; k++;
    end
    chk("drain_pending", 64'(mq.size() + rq0.size() + rq1.size()), 64'h0);
  endtask

  task automatic wait_resp0(output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (!resp_valid[0] && k < 50);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_op[i] = '0; req_data[i] = '0; resp_rdy[i] = 1'b1;
    end
    tgt_delay = 0; tgt_resp = 2'd0; tgt_data = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_m_req_valid", 64'(m_req_valid), 64'h0);
    chk("rst_m_resp_ready", 64'(m_resp_ready), 64'h1);
    chk("rst_resp_valid", 64'({resp_valid[0], resp_valid[1]}), 64'h0);
    chk("rst_req_ready", 64'({req_ready[0], req_ready[1]}), 64'h0);
    chk("rst_timeout_err", 64'(timeout_err), 64'h0);
    chk("rst_m_req_fields", 64'({m_req_addr, m_req_op, m_req_data}), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Both requesters continuously issuing writes: grants alternate starting with r0.
    for (int i = 0; i < 3; i++) begin
      mq.push_back({7'(32'h20 + i), 2'd2, 32'hA000_0000 + i});
      mq.push_back({7'(32'h40 + i), 2'd2, 32'hB000_0000 + i});
      rq0.push_back({2'd0, 32'h0});
      rq1.push_back({2'd0, 32'h0});
    end
    fork
      begin for (int i = 0; i < 3; i++) send(0, 7'(32'h20 + i), 2'd2, 32'hA000_0000 + i); end
      begin for (int i = 0; i < 3; i++) send(1, 7'(32'h40 + i), 2'd2, 32'hB000_0000 + i); end
    join
    drain();

    // Single read, reply 3 cycles into WAIT.
    @(posedge clk); #1;
    tgt_delay = 3; tgt_resp = 2'd0; tgt_data = 32'hDEADBEEF;
    mq.push_back({7'h11, 2'd1, 32'h0});
    rq0.push_back({2'd0, 32'hDEADBEEF});
    send(0, 7'h11, 2'd1, 32'h0);
    wait_resp0(k);
    chk("read_latency", 64'(k), 64'd6);
    drain();
    @(negedge clk);
    chk("busy_after_resp", 64'(busy), 64'h0);

    // Owner stalls the response; r1 must wait.
    @(posedge clk); #1;
    tgt_delay = 0; tgt_data = 32'h0BADCAFE;
    resp_rdy[0] = 1'b0;
    mq.push_back({7'h0A, 2'd1, 32'h0});
    mq.push_back({7'h0B, 2'd2, 32'h55AA55AA});
    rq0.push_back({2'd0, 32'h0BADCAFE});
    rq1.push_back({2'd0, 32'h0BADCAFE});
    fork
      send(0, 7'h0A, 2'd1, 32'h0);
      begin @(posedge clk); #1; send(1, 7'h0B, 2'd2, 32'h55AA55AA); end
      begin
        wait_resp0(k);
        for (int c = 0; c < 5; c++) begin
          if (c != 0) @(negedge clk);
          chk("stall_valid", 64'(resp_valid[0]), 64'h1);
          chk("stall_data", 64'({resp_code[0], resp_data[0]}), {30'h0, 2'd0, 32'h0BADCAFE});
          chk("stall_m_resp_ready", 64'(m_resp_ready), 64'h0);
          chk("stall_r1_ready", 64'(req_ready[1]), 64'h0);
        end
        @(posedge clk); #1;
        resp_rdy[0] = 1'b1;
      end
    join
    drain();

    // Response lands exactly on the expiry cycle: target value wins.
    @(posedge clk); #1;
    tgt_delay = 7; tgt_resp = 2'd3; tgt_data = 32'h77;
    mq.push_back({7'h07, 2'd1, 32'h0});
    rq0.push_back({2'd3, 32'h77});
    send(0, 7'h07, 2'd1, 32'h0);
    wait_resp0(k);
    chk("edge_latency", 64'(k), 64'd10);
    drain();
    chk("edge_timeout_err", 64'(timeout_err), 64'h0);

    // Reset in WAIT abandons r1's transaction; late reply is drained.
    @(posedge clk); #1;
    tgt_delay = 20; tgt_resp = 2'd0; tgt_data = 32'h12345678;
    mq.push_back({7'h3C, 2'd1, 32'h0});
    send(1, 7'h3C, 2'd1, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_busy_before", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_busy", 64'(busy), 64'h0);
    chk("mid_m_req_valid", 64'(m_req_valid), 64'h0);
    chk("mid_m_resp_ready", 64'(m_resp_ready), 64'h1);
    chk("mid_resp_valid", 64'({resp_valid[0], resp_valid[1]}), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    tgt_delay = 0; tgt_data = 32'h1111;
    mq.push_back({7'h01, 2'd0, 32'h0});
    mq.push_back({7'h02, 2'd0, 32'h0});
    rq0.push_back({2'd0, 32'h1111});
    rq1.push_back({2'd0, 32'h1111});
    fork
      send(0, 7'h01, 2'd0, 32'h0);
      send(1, 7'h02, 2'd0, 32'h0);
    join
    drain();

    // Hung target: failed response after 8 WAIT cycles, late reply dropped.
    @(posedge clk); #1;
    tgt_delay = 20; tgt_resp = 2'd0; tgt_data = 32'h12345678;
    mq.push_back({7'h05, 2'd1, 32'h0});
    rq0.push_back({2'd2, 32'h0});
    send(0, 7'h05, 2'd1, 32'h0);
    wait_resp0(k);
    chk("tmo_latency", 64'(k), 64'd10);
    chk("tmo_err", 64'(timeout_err), 64'h1);
    repeat (30) @(posedge clk);
    #1;
    chk("tmo_err_sticky", 64'(timeout_err), 64'h1);
    chk("tmo_idle_after_late", 64'(busy), 64'h0);
    tgt_delay = 1; tgt_data = 32'hCAFEF00D;
    mq.push_back({7'h33, 2'd1, 32'h0});
    rq1.push_back({2'd0, 32'hCAFEF00D});
    send(1, 7'h33, 2'd1, 32'h0);
    drain();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    tot++;
    $display("FAIL watchdog act=running exp=finished");
    $display("test done: total=%0d bad=%0d", tot, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
